// File: rtl/mem_stage_lsu_pkg.sv
// Shared widths, access-size and FSM encodings, and the latched control word for the MEM-stage LSU.
package mem_stage_lsu_pkg;

    localparam int LSU_XLEN      = 64;
    localparam int LSU_REG_IDX_W = 5;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] MEM_SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic       load;
        logic       store;
        logic [1:0] size;
        logic       uns;
        logic       rd_en;
    } lsu_ctl_t;

    // Byte-enable pattern of an access starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_mask = 8'h01;
            MEM_SIZE_H: size_mask = 8'h03;
            MEM_SIZE_W: size_mask = 8'h0F;
            default:    size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Purpose: byte-lane placement of store data/strobes, load lane extract + sign/zero extend, misalign detect.
// Latency: purely combinational.
// Backpressure: none; it has no handshake of its own.
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data,
    output logic            misalign
);

    logic [3:0]      nbytes;
    logic [5:0]      bit_shift;
    logic [XLEN-1:0] lane;

    assign nbytes    = 4'd1 << size;
    assign bit_shift = {offset, 3'b000};
    assign misalign  = ({1'b0, offset} + nbytes) > 4'd8;
    assign wstrb     = size_mask(size) << offset;
    assign wdata     = st_data << bit_shift;
    assign lane      = rdata >> bit_shift;

    always_comb begin
        ld_data = lane;
        case (size)
            MEM_SIZE_B: ld_data = {{(XLEN-8){~uns & lane[7]}},   lane[7:0]};
            MEM_SIZE_H: ld_data = {{(XLEN-16){~uns & lane[15]}}, lane[15:0]};
            MEM_SIZE_W: ld_data = {{(XLEN-32){~uns & lane[31]}}, lane[31:0]};
            default:    ld_data = lane;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Purpose: MEM-stage load/store unit: dmem req/gnt/rvalid handshake, MEM/WB register, MEM forwarding source.
// Latency: ALU ops and granted stores retire 1 cycle after acceptance; loads retire 1 cycle after rvalid.
// Backpressure: in_ready_o drops outside IDLE; mem_stall_o also covers an incoming ld/st not granted yet.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN      = LSU_XLEN,
    parameter int REG_IDX_W = LSU_REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [1:0]           mem_size_i,
    input  logic                 mem_unsigned_i,
    input  logic                 rd_en_i,
    input  logic [REG_IDX_W-1:0] rd_index_i,
    input  logic [XLEN-1:0]      res_data_i,
    input  logic [XLEN-1:0]      st_data_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [XLEN-1:0]      dmem_addr_o,
    output logic [XLEN-1:0]      dmem_wdata_o,
    output logic [7:0]           dmem_wstrb_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [XLEN-1:0]      dmem_rdata_i,
    output logic                 fwd_rd_en_o,
    output logic [REG_IDX_W-1:0] fwd_rd_index_o,
    output logic [XLEN-1:0]      fwd_rd_data_o,
    output logic                 load_busy_o,
    output logic                 mem_stall_o,
    output logic                 misalign_o,
    output logic                 wb_valid_o,
    output logic                 wb_rd_en_o,
    output logic [REG_IDX_W-1:0] wb_rd_index_o,
    output logic [XLEN-1:0]      wb_rd_data_o
);

    lsu_state_e           state;
    lsu_ctl_t             lat_ctl;
    logic [REG_IDX_W-1:0] lat_rd_index;
    logic [XLEN-1:0]      lat_addr;
    logic [XLEN-1:0]      lat_st_data;

    logic            idle;
    logic            in_mem;
    logic            issue_now;
    logic            req_active;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_st_data;
    logic [1:0]      sel_size;
    logic            sel_uns;
    logic [7:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_ld_data;
    logic            al_misalign;
    logic            fwd_en;

    assign idle   = (state == LSU_IDLE);
    assign in_mem = in_valid_i && (mem_read_i || mem_write_i);

    // In IDLE the lane logic works on the incoming payload so the request can go out in the accepting cycle.
    assign sel_addr    = idle ? res_data_i     : lat_addr;
    assign sel_st_data = idle ? st_data_i      : lat_st_data;
    assign sel_size    = idle ? mem_size_i     : lat_ctl.size;
    assign sel_uns     = idle ? mem_unsigned_i : lat_ctl.uns;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .offset   (sel_addr[2:0]),
        .size     (sel_size),
        .uns      (sel_uns),
        .st_data  (sel_st_data),
        .rdata    (dmem_rdata_i),
        .wstrb    (al_wstrb),
        .wdata    (al_wdata),
        .ld_data  (al_ld_data),
        .misalign (al_misalign)
    );

    assign issue_now  = idle && in_mem && !al_misalign;
    assign req_active = issue_now || (state == LSU_REQ);

    assign dmem_req_o   = req_active;
    assign dmem_we_o    = req_active && (idle ? mem_write_i : lat_ctl.store);
    assign dmem_addr_o  = req_active ? {sel_addr[XLEN-1:3], 3'b000} : '0;
    assign dmem_wdata_o = req_active ? al_wdata : '0;
    assign dmem_wstrb_o = req_active ? al_wstrb : '0;

    assign in_ready_o  = idle;
    assign mem_stall_o = !idle || (issue_now && !dmem_gnt_i);
    assign load_busy_o = (!idle && lat_ctl.load) || (issue_now && mem_read_i);

    // Load results never forward from here; the consumer picks them up from wb_* instead.
    assign fwd_en = idle ? (in_valid_i && rd_en_i && !mem_read_i && (rd_index_i != '0))
                         : (lat_ctl.rd_en && !lat_ctl.load && (lat_rd_index != '0));
    assign fwd_rd_en_o    = fwd_en;
    assign fwd_rd_index_o = fwd_en ? (idle ? rd_index_i : lat_rd_index) : '0;
    assign fwd_rd_data_o  = fwd_en ? sel_addr : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= LSU_IDLE;
            lat_ctl       <= '0;
            lat_rd_index  <= '0;
            lat_addr      <= '0;
            lat_st_data   <= '0;
            misalign_o    <= 1'b0;
            wb_valid_o    <= 1'b0;
            wb_rd_en_o    <= 1'b0;
            wb_rd_index_o <= '0;
            wb_rd_data_o  <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (in_valid_i && !in_mem) begin
                        wb_valid_o    <= 1'b1;
                        wb_rd_en_o    <= rd_en_i && (rd_index_i != '0);
                        wb_rd_index_o <= rd_index_i;
                        wb_rd_data_o  <= res_data_i;
                    end else if (in_mem && al_misalign) begin
                        misalign_o <= 1'b1;
                        wb_valid_o <= 1'b1;
                        wb_rd_en_o <= 1'b0;
                    end else if (issue_now) begin
                        lat_ctl      <= '{load: mem_read_i, store: mem_write_i, size: mem_size_i,
                                          uns: mem_unsigned_i, rd_en: rd_en_i};
                        lat_rd_index <= rd_index_i;
                        lat_addr     <= res_data_i;
                        lat_st_data  <= st_data_i;
                        if (!dmem_gnt_i) begin
                            state <= LSU_REQ;
                        end else if (mem_write_i) begin
                            wb_valid_o <= 1'b1;
                            wb_rd_en_o <= 1'b0;
                        end else begin
                            state <= LSU_RESP;
                        end
                    end
                end
                LSU_REQ: begin
                    if (dmem_gnt_i) begin
                        if (lat_ctl.store) begin
                            wb_valid_o <= 1'b1;
                            wb_rd_en_o <= 1'b0;
                            state      <= LSU_IDLE;
                        end else begin
                            state <= LSU_RESP;
                        end
                    end
                end
                LSU_RESP: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_o    <= 1'b1;
                        wb_rd_en_o    <= lat_ctl.rd_en && (lat_rd_index != '0);
                        wb_rd_index_o <= lat_rd_index;
                        wb_rd_data_o  <= al_ld_data;
                        state         <= LSU_IDLE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: vector table for single-transaction accesses, plus stalled-load and reset-in-RESP sequences.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i, in_ready_o;
    logic        mem_read_i, mem_write_i, mem_unsigned_i, rd_en_i;
    logic [1:0]  mem_size_i;
    logic [4:0]  rd_index_i;
    logic [63:0] res_data_i, st_data_i;
    logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic [63:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [7:0]  dmem_wstrb_o;
    logic        fwd_rd_en_o, load_busy_o, mem_stall_o, misalign_o;
    logic [4:0]  fwd_rd_index_o, wb_rd_index_o;
    logic [63:0] fwd_rd_data_o, wb_rd_data_o;
    logic        wb_valid_o, wb_rd_en_o;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .rd_en_i(rd_en_i), .rd_index_i(rd_index_i),
        .res_data_i(res_data_i), .st_data_i(st_data_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .fwd_rd_en_o(fwd_rd_en_o), .fwd_rd_index_o(fwd_rd_index_o), .fwd_rd_data_o(fwd_rd_data_o),
        .load_busy_o(load_busy_o), .mem_stall_o(mem_stall_o), .misalign_o(misalign_o),
        .wb_valid_o(wb_valid_o), .wb_rd_en_o(wb_rd_en_o),
        .wb_rd_index_o(wb_rd_index_o), .wb_rd_data_o(wb_rd_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rd, wr;
        logic [1:0]  sz;
        logic        uns, rd_en;
        logic [4:0]  idx;
        logic [63:0] res, st, rdata;
        logic        exp_mis;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
        logic        exp_wb_en;
        logic [63:0] exp_wb_data;
    } vec_t;

    typedef struct {
        logic        en;
        logic [4:0]  idx;
        logic [63:0] data;
    } wb_exp_t;

    vec_t    vecs[$];
    wb_exp_t sb[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wb(input logic en, input logic [4:0] idx, input logic [63:0] data);
        wb_exp_t e;
        e.en = en; e.idx = idx; e.data = data;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        in_valid_i = 0; mem_read_i = 0; mem_write_i = 0; mem_size_i = 0; mem_unsigned_i = 0;
        rd_en_i = 0; rd_index_i = 0; res_data_i = 0; st_data_i = 0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    endtask

    // Scoreboard consumer: every wb_valid pulse must match the oldest expected retirement.
    always @(negedge clk) begin
        if (rst === 1'b1 && wb_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got wb_valid with idx %0d data 0x%0h, expected none",
                         wb_rd_index_o, wb_rd_data_o);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_rd_en", 64'(wb_rd_en_o), 64'(e.en));
                if (e.en) begin
                    chk("wb_rd_index", 64'(wb_rd_index_o), 64'(e.idx));
                    chk("wb_rd_data", wb_rd_data_o, e.data);
                end
            end
        end
    end

    initial begin
        vec_t v;
        logic exp_req, exp_fwd;
        idle_inputs();
        rst = 0;

        vecs.push_back('{"alu_rd5",  0,0,2'd0,0,1,5'd5,  64'h1234,0,0, 0,8'h00,64'h0, 1,64'h1234});
        vecs.push_back('{"alu_x0",   0,0,2'd0,0,1,5'd0,  64'h55,  0,0, 0,8'h00,64'h0, 0,64'h0});
        vecs.push_back('{"sb_1003",  0,1,2'd0,0,0,5'd0,  64'h1003,64'hAB,0, 0,8'h08,64'h0000_0000_AB00_0000, 0,64'h0});
        vecs.push_back('{"sh_1006",  0,1,2'd1,0,0,5'd0,  64'h1006,64'hBEEF,0, 0,8'hC0,64'hBEEF_0000_0000_0000, 0,64'h0});
        vecs.push_back('{"sd_2000",  0,1,2'd3,0,0,5'd0,  64'h2000,64'h1122_3344_5566_7788,0,
                         0,8'hFF,64'h1122_3344_5566_7788, 0,64'h0});
        vecs.push_back('{"lwu_1004", 1,0,2'd2,1,1,5'd7,  64'h1004,0,64'h8000_0001_0000_0000,
                         0,8'h00,64'h0, 1,64'h0000_0000_8000_0001});
        vecs.push_back('{"lw_1004",  1,0,2'd2,0,1,5'd8,  64'h1004,0,64'h8000_0001_0000_0000,
                         0,8'h00,64'h0, 1,64'hFFFF_FFFF_8000_0001});
        vecs.push_back('{"lh_1002",  1,0,2'd1,0,1,5'd10, 64'h1002,0,64'h0000_0000_8001_0000,
                         0,8'h00,64'h0, 1,64'hFFFF_FFFF_FFFF_8001});
        vecs.push_back('{"lhu_1002", 1,0,2'd1,1,1,5'd11, 64'h1002,0,64'h0000_0000_8001_0000,
                         0,8'h00,64'h0, 1,64'h0000_0000_0000_8001});
        vecs.push_back('{"lbu_1007", 1,0,2'd0,1,1,5'd12, 64'h1007,0,64'hF000_0000_0000_0000,
                         0,8'h00,64'h0, 1,64'h0000_0000_0000_00F0});
        vecs.push_back('{"ld_1008",  1,0,2'd3,0,1,5'd13, 64'h1008,0,64'hDEAD_BEEF_CAFE_F00D,
                         0,8'h00,64'h0, 1,64'hDEAD_BEEF_CAFE_F00D});
        vecs.push_back('{"ld_x0",    1,0,2'd3,0,1,5'd0,  64'h1010,0,64'h1111_2222_3333_4444,
                         0,8'h00,64'h0, 0,64'h0});
        vecs.push_back('{"ld_mis",   1,0,2'd3,0,1,5'd14, 64'h1004,0,0, 1,8'h00,64'h0, 0,64'h0});
        vecs.push_back('{"sw_mis",   0,1,2'd2,0,0,5'd0,  64'h1006,64'h5A,0, 1,8'h00,64'h0, 0,64'h0});
        vecs.push_back('{"sh_mis",   0,1,2'd1,0,0,5'd0,  64'h1007,64'h5A,0, 1,8'h00,64'h0, 0,64'h0});

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready_o), 64'd1);
        chk("rst_dmem_req",  64'(dmem_req_o), 64'd0);
        chk("rst_dmem_misc", 64'({dmem_we_o, dmem_wstrb_o}), 64'd0);
        chk("rst_dmem_addr", dmem_addr_o | dmem_wdata_o, 64'd0);
        chk("rst_wb_valid",  64'({wb_valid_o, wb_rd_en_o, wb_rd_index_o}), 64'd0);
        chk("rst_wb_data",   wb_rd_data_o, 64'd0);
        chk("rst_fwd",       64'({fwd_rd_en_o, fwd_rd_index_o}) | fwd_rd_data_o, 64'd0);
        chk("rst_flags",     64'({misalign_o, load_busy_o, mem_stall_o}), 64'd0);
        @(negedge clk);
        rst = 1;

        // Table: one access each, granted in the accepting cycle, load data the cycle after.
        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            in_valid_i = 1; mem_read_i = v.rd; mem_write_i = v.wr; mem_size_i = v.sz;
            mem_unsigned_i = v.uns; rd_en_i = v.rd_en; rd_index_i = v.idx;
            res_data_i = v.res; st_data_i = v.st; dmem_gnt_i = v.rd | v.wr;
            #1;
            exp_req = (v.rd | v.wr) & ~v.exp_mis;
            exp_fwd = v.rd_en & ~v.rd & (v.idx != 0);
            chk({v.nm, "_req"}, 64'(dmem_req_o), 64'(exp_req));
            chk({v.nm, "_stall"}, 64'(mem_stall_o), 64'd0);
            chk({v.nm, "_busy"}, 64'(load_busy_o), 64'(v.rd & ~v.exp_mis));
            chk({v.nm, "_fwd_en"}, 64'(fwd_rd_en_o), 64'(exp_fwd));
            if (exp_fwd) chk({v.nm, "_fwd_data"}, fwd_rd_data_o, v.res);
            if (exp_req) begin
                chk({v.nm, "_we"}, 64'(dmem_we_o), 64'(v.wr));
                chk({v.nm, "_addr"}, dmem_addr_o, {v.res[63:3], 3'b000});
            end
            if (exp_req && v.wr) begin
                chk({v.nm, "_wstrb"}, 64'(dmem_wstrb_o), 64'(v.exp_wstrb));
                chk({v.nm, "_wdata"}, dmem_wdata_o, v.exp_wdata);
            end
            if (!exp_req || v.wr) push_wb(v.exp_wb_en, v.idx, v.exp_wb_data);
            @(negedge clk);
            chk({v.nm, "_misalign"}, 64'(misalign_o), 64'(v.exp_mis));
            idle_inputs();
            if (exp_req && v.rd) begin
                dmem_rvalid_i = 1; dmem_rdata_i = v.rdata;
                #1;
                chk({v.nm, "_resp_busy"}, 64'({load_busy_o, mem_stall_o, in_ready_o}), 64'b110);
                push_wb(v.exp_wb_en, v.idx, v.exp_wb_data);
                @(negedge clk);
                idle_inputs();
            end
        end

        // lb 0x1005: gnt two cycles late, rvalid three cycles after gnt.
        @(negedge clk);
        in_valid_i = 1; mem_read_i = 1; mem_size_i = 2'd0; rd_en_i = 1; rd_index_i = 5'd9;
        res_data_i = 64'h1005;
        #1;
        chk("lb_acc_req", 64'({dmem_req_o, mem_stall_o, load_busy_o}), 64'b111);
        chk("lb_acc_addr", dmem_addr_o, 64'h1000);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("lb_req1", 64'({dmem_req_o, dmem_we_o, mem_stall_o, load_busy_o, in_ready_o}), 64'b10110);
        chk("lb_req1_addr", dmem_addr_o, 64'h1000);
        chk("lb_req1_fwd", 64'(fwd_rd_en_o), 64'd0);
        @(negedge clk);
        dmem_gnt_i = 1;
        #1;
        chk("lb_gnt", 64'({dmem_req_o, mem_stall_o, load_busy_o}), 64'b111);
        chk("lb_gnt_addr", dmem_addr_o, 64'h1000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dmem_gnt_i = 0;
            if (c == 2) begin
                dmem_rvalid_i = 1; dmem_rdata_i = 64'h0000_8000_0000_0000;
                push_wb(1'b1, 5'd9, 64'hFFFF_FFFF_FFFF_FF80);
            end
            #1;
            chk("lb_resp", 64'({dmem_req_o, mem_stall_o, load_busy_o, fwd_rd_en_o}), 64'b0110);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("lb_done", 64'({in_ready_o, mem_stall_o, load_busy_o}), 64'b100);

        // Reset asserted while a load waits in RESP.
        @(negedge clk);
        in_valid_i = 1; mem_read_i = 1; mem_size_i = 2'd3; rd_en_i = 1; rd_index_i = 5'd4;
        res_data_i = 64'h1000; dmem_gnt_i = 1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rr_in_resp", 64'({load_busy_o, in_ready_o}), 64'b10);
        #2;
        rst = 0;
        #1;
        chk("rr_flags", 64'({in_ready_o, load_busy_o, mem_stall_o, misalign_o, dmem_req_o}), 64'b10000);
        chk("rr_wb", 64'({wb_valid_o, wb_rd_en_o, wb_rd_index_o}), 64'd0);
        chk("rr_wb_data", wb_rd_data_o, 64'd0);
        chk("rr_fwd", 64'({fwd_rd_en_o, fwd_rd_index_o}) | fwd_rd_data_o, 64'd0);
        @(negedge clk);
        rst = 1;
        dmem_rvalid_i = 1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("rr_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk);
        idle_inputs();
        in_valid_i = 1; rd_en_i = 1; rd_index_i = 5'd3; res_data_i = 64'hCAFE;
        push_wb(1'b1, 5'd3, 64'hCAFE);
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
